// File: rtl/sqrtlog_iter.sv
// Bit-serial fixed-point evaluator for sqrt, log2, log10 and ln of an unsigned Q operand.
// One result bit retires per cycle; start/busy/done handshake with an error flag for log(0).
module sqrtlog_iter #(
    parameter int NBITS = 16,
    parameter int FRAC  = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [NBITS-1:0] i_data_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [NBITS-1:0] o_data_out
);

    // state | meaning
    // IDLE  | waiting for start
    // NORM  | leading-one detect, mantissa normalise, zero check
    // SQRT  | one restoring root bit per cycle
    // LOGF  | one log2 fraction bit per cycle by repeated squaring
    // SCALE | log2 times base-conversion constant
    // FIN   | publish result, pulse done
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_NORM  = 3'd1;
    localparam logic [2:0] S_SQRT  = 3'd2;
    localparam logic [2:0] S_LOGF  = 3'd3;
    localparam logic [2:0] S_SCALE = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam int SQ_IT = (NBITS + FRAC + 1) / 2;
    localparam int RAD_W = 2 * SQ_IT;
    localparam int REM_W = SQ_IT + 2;
    localparam int IW    = NBITS - FRAC;
    localparam int PW    = $clog2(NBITS);
    localparam int MAXC  = (SQ_IT > FRAC) ? SQ_IT : FRAC;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [NBITS-1:0] MOST_NEG = {1'b1, {(NBITS-1){1'b0}}};

    // Base-conversion constants held as Q0.32 and rounded to FRAC bits at elaboration
    localparam logic [63:0] LOG10_2_Q32 = 64'd1292913986;
    localparam logic [63:0] LN_2_Q32    = 64'd2977044472;
    localparam logic [NBITS-1:0] K_LOG10 =
        NBITS'(((LOG10_2_Q32 << FRAC) + 64'h8000_0000) >> 32);
    localparam logic [NBITS-1:0] K_LN =
        NBITS'(((LN_2_Q32 << FRAC) + 64'h8000_0000) >> 32);

    logic [2:0]       r_state;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [RAD_W-1:0] r_rad;
    logic [SQ_IT-1:0] r_rem;
    logic [SQ_IT-1:0] r_root;
    logic [FRAC:0]    r_m;
    logic [FRAC-1:0]  r_frac;
    logic [IW-1:0]    r_int;
    logic [NBITS-1:0] r_res;
    logic             r_err_pend;

    logic [NBITS-1:0] w_data;
    logic [PW-1:0]    w_pos;
    logic [PW-1:0]    w_shamt;
    logic [NBITS-1:0] w_norm;
    logic [FRAC:0]    w_mant;
    logic [IW-1:0]    w_int;

    logic [REM_W-1:0] w_rem_sh;
    logic [REM_W-1:0] w_trial;
    logic             w_ge;
    logic [REM_W-1:0] w_rem_nx;
    logic [SQ_IT-1:0] w_root_nx;

    logic [2*FRAC+1:0] w_sq;
    logic [FRAC+1:0]   w_sq_t;
    logic              w_bit;
    logic [FRAC:0]     w_m_nx;
    logic [FRAC-1:0]   w_frac_nx;

    logic [NBITS-1:0]         w_k;
    logic signed [2*NBITS-1:0] w_l2_ext;
    logic signed [2*NBITS-1:0] w_k_ext;
    logic signed [2*NBITS-1:0] w_prod;
    logic [NBITS-1:0]         w_scaled;
    logic                     w_unused;

    // The operand stays in the radicand register, already shifted up by FRAC
    assign w_data = r_rad[FRAC +: NBITS];

    always_comb begin
        w_pos = '0;
        for (int i = 0; i < NBITS; i++) begin
            if (w_data[i]) begin
                w_pos = PW'(i);
            end
        end
    end

    assign w_shamt = PW'(NBITS - 1) - w_pos;
    assign w_norm  = w_data << w_shamt;
    assign w_mant  = w_norm[NBITS-1 -: FRAC+1];
    assign w_int   = IW'(w_pos) - IW'(FRAC);

    assign w_rem_sh  = {r_rem, r_rad[RAD_W-1 -: 2]};
    assign w_trial   = {r_root, 2'b01};
    assign w_ge      = (w_rem_sh >= w_trial);
    assign w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nx = {r_root[SQ_IT-2:0], w_ge};

    // Square in Q2.(2*FRAC), then drop back to FRAC fractional bits
    assign w_sq      = (2*FRAC+2)'(r_m) * (2*FRAC+2)'(r_m);
    assign w_sq_t    = w_sq[2*FRAC+1:FRAC];
    assign w_bit     = w_sq_t[FRAC+1];
    assign w_m_nx    = w_bit ? w_sq_t[FRAC+1:1] : w_sq_t[FRAC:0];
    assign w_frac_nx = (r_frac << 1) | FRAC'(w_bit);

    assign w_k      = (r_op == 2'd2) ? K_LOG10 : K_LN;
    assign w_l2_ext = {{NBITS{r_res[NBITS-1]}}, r_res};
    assign w_k_ext  = {{NBITS{1'b0}}, w_k};
    assign w_prod   = w_l2_ext * w_k_ext;
    // Taking bits from FRAC upward is the floor of the arithmetic shift
    assign w_scaled = w_prod[FRAC +: NBITS];

    assign w_unused = ^{w_sq[FRAC-1:0], w_norm[NBITS-FRAC-2:0],
                        w_prod[2*NBITS-1:FRAC+NBITS], w_prod[FRAC-1:0],
                        w_rem_nx[REM_W-1:SQ_IT]};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_data_out <= '0;
            r_err_pend <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op       <= i_op;
                        r_rad      <= RAD_W'(i_data_in) << FRAC;
                        r_rem      <= '0;
                        r_root     <= '0;
                        r_cnt      <= CNT_W'(SQ_IT);
                        o_err      <= 1'b0;
                        r_err_pend <= 1'b0;
                        o_busy     <= 1'b1;
                        r_state    <= (i_op == 2'd0) ? S_SQRT : S_NORM;
                    end
                end
                S_NORM: begin
                    if (w_data == '0) begin
                        r_res      <= MOST_NEG;
                        r_err_pend <= 1'b1;
                        r_state    <= S_FIN;
                    end else begin
                        r_int   <= w_int;
                        r_m     <= w_mant;
                        r_frac  <= '0;
                        r_cnt   <= CNT_W'(FRAC);
                        r_state <= S_LOGF;
                    end
                end
                S_SQRT: begin
                    r_rem  <= w_rem_nx[SQ_IT-1:0];
                    r_root <= w_root_nx;
                    r_rad  <= r_rad << 2;
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_res   <= NBITS'(w_root_nx);
                        r_state <= S_FIN;
                    end
                end
                S_LOGF: begin
                    r_m    <= w_m_nx;
                    r_frac <= w_frac_nx;
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_res   <= {r_int, w_frac_nx};
                        r_state <= (r_op == 2'd1) ? S_FIN : S_SCALE;
                    end
                end
                S_SCALE: begin
                    r_res   <= w_scaled;
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    o_data_out <= r_res;
                    o_err      <= r_err_pend;
                    o_done     <= 1'b1;
                    o_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrtlog_iter.sv
// Randomised and directed bench for sqrtlog_iter against an arithmetic reference model
// with a cycle-level timeline of busy/done/err/data_out.
module tb_sqrtlog_iter;

    localparam int NBITS = 16;
    localparam int FRAC  = 8;
    localparam int SQ_IT = (NBITS + FRAC + 1) / 2;
    localparam int K10   = int'(0.301029995664 * (2.0 ** FRAC));
    localparam int KLN   = int'(0.693147180560 * (2.0 ** FRAC));

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [NBITS-1:0] din;
    logic             busy;
    logic             done;
    logic             err;
    logic [NBITS-1:0] dout;

    int checks   = 0;
    int failures = 0;

    sqrtlog_iter #(.NBITS(NBITS), .FRAC(FRAC)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_op       (op),
        .i_data_in  (din),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err),
        .o_data_out (dout)
    );

    always #5 clk = ~clk;

    function automatic longint isqrt(longint x);
        longint r = 0;
        for (int b = SQ_IT - 1; b >= 0; b--) begin
            longint t = r | (longint'(1) << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    function automatic logic [NBITS-1:0] ref_result(logic [1:0] o, logic [NBITS-1:0] x);
        int p = 0;
        longint m, f, l2, k;
        if (o == 2'd0) return NBITS'(isqrt(longint'(x) << FRAC));
        if (x == '0) return NBITS'(longint'(1) << (NBITS - 1));
        for (int i = 0; i < NBITS; i++) if (x[i]) p = i;
        m = (p >= FRAC) ? (longint'(x) >> (p - FRAC)) : (longint'(x) << (FRAC - p));
        f = 0;
        for (int i = 0; i < FRAC; i++) begin
            m = (m * m) >> FRAC;
            f = f * 2;
            if (m >= (longint'(2) << FRAC)) begin
                f = f + 1;
                m = m >> 1;
            end
        end
        l2 = longint'(p - FRAC) * (longint'(1) << FRAC) + f;
        if (o == 2'd1) return NBITS'(l2);
        k = (o == 2'd2) ? longint'(K10) : longint'(KLN);
        return NBITS'((l2 * k) >>> FRAC);
    endfunction

    function automatic int ref_latency(logic [1:0] o, logic [NBITS-1:0] x);
        if (o == 2'd0) return SQ_IT + 1;
        if (x == '0) return 2;
        if (o == 2'd1) return FRAC + 2;
        return FRAC + 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: acceptance, countdown to done, held outputs
    logic             m_valid = 1'b0;
    logic             m_busy  = 1'b0;
    logic             m_done  = 1'b0;
    logic             m_err   = 1'b0;
    logic             m_errp  = 1'b0;
    logic [NBITS-1:0] m_dout  = '0;
    logic [NBITS-1:0] m_res   = '0;
    int               m_cnt   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_dout  = '0;
            m_cnt   = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_err  = 1'b0;
                    m_res  = ref_result(op, din);
                    m_errp = (op != 2'd0) && (din == '0);
                    m_cnt  = ref_latency(op, din);
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_dout = m_res;
                    m_err  = m_errp;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_err",  32'(err),  32'(m_err));
            chk("cyc_data", 32'(dout), 32'(m_dout));
        end
    end

    // Called at posedge+1 with the DUT idle or in its done cycle
    task automatic do_op(input logic [1:0] o, input logic [NBITS-1:0] x,
                         output int lat, output logic [NBITS-1:0] res, output logic e);
        start = 1'b1;
        op    = o;
        din   = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        din   = NBITS'($urandom);
        lat   = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        res = dout;
        e   = err;
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done op=%0d data=%h", o, x);
        end else begin
            chk("latency", 32'(lat), 32'(ref_latency(o, x)));
        end
    endtask

    task automatic near(input string name, input logic [NBITS-1:0] act,
                        input logic [NBITS-1:0] exp, input int tol);
        int d;
        d = int'($signed(act)) - int'($signed(exp));
        checks++;
        if (d > tol || d < -tol) begin
            failures++;
            $display("FAIL %s actual=%h required=%h tol=%0d", name, act, exp, tol);
        end
    endtask

    task automatic lit(input string name, input logic [1:0] o, input logic [NBITS-1:0] x,
                       input logic [NBITS-1:0] exp, input int tol, input int exp_lat,
                       input logic exp_err);
        int lat;
        logic [NBITS-1:0] res;
        logic e;
        near({name, "_model"}, ref_result(o, x), exp, tol);
        do_op(o, x, lat, res, e);
        near(name, res, exp, tol);
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_err"}, 32'(e), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, gap, saw;
        logic [NBITS-1:0] res, x;
        logic [1:0] o;
        logic e;

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        din   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err",  32'(err),  32'd0);
        chk("reset_data", 32'(dout), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        lit("sqrt4",    2'd0, 16'h0400, 16'h0200, 0, 13, 1'b0);
        lit("sqrt0",    2'd0, 16'h0000, 16'h0000, 0, 13, 1'b0);
        lit("sqrtmax",  2'd0, 16'hFFFF, 16'h0FFF, 0, 13, 1'b0);
        lit("log2_8",   2'd1, 16'h0800, 16'h0300, 0, 10, 1'b0);
        lit("log2_half",2'd1, 16'h0080, 16'hFF00, 0, 10, 1'b0);
        lit("log2_lsb", 2'd1, 16'h0001, 16'hF800, 0, 10, 1'b0);
        lit("log10_100",2'd2, 16'h6400, 16'h0200, 2, 11, 1'b0);
        lit("ln_e",     2'd3, 16'h02B8, 16'h0100, 2, 11, 1'b0);
        lit("log2_zero",2'd1, 16'h0000, 16'h8000, 0, 2,  1'b1);
        lit("sqrt1",    2'd0, 16'h0100, 16'h0100, 0, 13, 1'b0);

        // Start with a different op while busy must be ignored
        start = 1'b1;
        op    = 2'd0;
        din   = 16'h0400;
        @(posedge clk);
        #1;
        op  = 2'd1;
        din = 16'h0800;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        lat = -1;
        for (int k = 4; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("busy_ign_lat",  32'(lat),  32'd13);
        chk("busy_ign_data", 32'(dout), 32'h0200);

        // Start in the done cycle is accepted immediately
        do_op(2'd1, 16'h0800, lat, res, e);
        chk("b2b_first", 32'(res), 32'h0300);
        do_op(2'd0, 16'h0100, lat, res, e);
        chk("b2b_second", 32'(res), 32'h0100);
        chk("b2b_lat", 32'(lat), 32'd13);
        @(posedge clk);
        #1;

        // Reset during LOGF aborts with no done pulse
        start = 1'b1;
        op    = 2'd1;
        din   = 16'h0080;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data", 32'(dout), 32'd0);
        chk("abort_err",  32'(err),  32'd0);
        saw = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) saw++;
        end
        chk("abort_no_done", 32'(saw), 32'd0);
        lit("after_abort", 2'd1, 16'h0800, 16'h0300, 0, 10, 1'b0);

        for (int n = 0; n < 300; n++) begin
            o = 2'($urandom_range(0, 3));
            x = NBITS'($urandom);
            x = x >> $urandom_range(0, NBITS - 1);
            if ($urandom_range(0, 15) == 0) x = '0;
            do_op(o, x, lat, res, e);
            chk("rand_data", 32'(res), 32'(ref_result(o, x)));
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sqrtlog_iter.md
# sqrtlog_iter

Parametrised, multi-cycle fixed-point evaluator for square root and logarithms (log2, log10, ln) of an unsigned Qm.f operand. It uses a start/busy/done handshake, an error flag for undefined inputs and a bit-serial datapath that retires one result bit per cycle. It is the generalised successor to the fixed-width SQRTLOG unit and sits behind any sequencer or testbench that issues one operation at a time.

## Interface
- NBITS, 16, total operand/result width.
- FRAC, 8, fractional bits of operand and result (0 < FRAC < NBITS).
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  0 sqrt, 1 log2, 2 log10, 3 ln; latched with start.
- data_in  in  NBITS  unsigned Q(NBITS-FRAC).FRAC operand; latched with start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; data_out/err valid from this cycle.
- err  out  1  log of zero; valid with done, held until next acceptance.
- data_out  out  NBITS  sqrt: unsigned Q format; log ops: two's-complement signed Q format.

## Operation
- States: IDLE, NORM, SQRT, LOGF, SCALE, FIN.
- IDLE: start=1 latches op and data_in, clears err. op=0 goes to SQRT; otherwise NORM. start while busy is ignored, with no queueing.
- SQRT: restoring digit-by-digit integer sqrt of {data_in, FRAC zeros}, SQ_IT = (NBITS+FRAC+1)/2 cycles, one result bit per cycle. Result truncated and zero-extended to NBITS. Goes to FIN.
- NORM (1 cycle): leading-one position p. Integer part = p - FRAC, signed. Mantissa m normalised to [1,2) with FRAC fractional bits. If data_in==0: err=1, result = 2^(NBITS-1) (most negative), go to FIN directly.
- LOGF: FRAC cycles. Each cycle m = m*m truncated to FRAC fractional bits. If m >= 2, the next fraction bit is 1 and m >>= 1; else the bit is 0. Bits are filled MSB first. After FRAC cycles: op=1 goes to FIN, ops 2/3 go to SCALE.
- SCALE (1 cycle): signed log2 value times unsigned constant K, arithmetic shift right by FRAC (floor). K = round(log10(2)*2^FRAC) for op 2 and round(ln(2)*2^FRAC) for op 3. Multiplier is 2*NBITS wide; no overflow is possible.
- FIN: register the result to data_out, pulse done, clear busy, return to IDLE.
- data_out holds its value between done pulses.
- Reset: state=IDLE, busy=0, done=0, err=0, data_out=0. Reset mid-operation aborts with no done pulse.

## Timing
- Acceptance edge = edge 0 (start=1 in IDLE).
- busy=1 from edge 0 through the edge where done rises; busy=0 in the done cycle.
- done high during the cycle after edge L:
  - sqrt: L = SQ_IT+1.
  - log2: L = FRAC+2.
  - log10/ln: L = FRAC+3.
  - zero-input log: L = 2.
- In the done cycle the block is already IDLE. start=1 in that cycle is accepted, giving back-to-back throughput.
- Accuracy: sqrt exact to truncation. log2 ≤ 1 LSB below the true value. log10/ln within ±2 LSB.

## Test plan
- Defaults, sqrt of 0x0400 (4.0): done at edge 13 with data_out 0x0200. Also sqrt of 0x0000 gives 0x0000 with err=0, and sqrt of 0xFFFF gives 0x0FFF.
- log2 of 0x0800 gives 0x0300, done at edge 10. log2 of 0x0080 (0.5) gives 0xFF00. log2 of 0x0001 gives 0xF800.
- log10 of 0x6400 (100.0) gives 0x01FF or 0x0200 (±2 LSB of 512). ln of 0x02B8 (e) gives 256 ±2. Each done at edge 11.
- log2 of 0x0000: err=1 and data_out=0x8000 with done at edge 2. Next sqrt of 0x0100 clears err and gives 0x0100.
- Assert start with a different op while busy: it is ignored and the result matches the first op. Start asserted in the done cycle: accepted, and the second done pulse arrives at the expected latency.
- Reset asserted mid-LOGF: no done pulse. Next cycle shows busy=0, data_out=0, err=0. A following operation completes correctly.
